// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and lane geometry.
package lsu_pkg;

  localparam int unsigned LANES = 4;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {StIdle, StRd, StWr, StRsp} state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: load extract with sign/zero extension, and sub-word store merge.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [1:0]        lane,
  input  logic [1:0]        size,
  input  logic              is_signed,
  input  logic [DATA_W-1:0] old_word,
  input  logic [DATA_W-1:0] new_data,
  output logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] store_word
);

  localparam int unsigned ByteW = DATA_W / LANES;
  localparam int unsigned HalfW = 2 * ByteW;

  logic [ByteW-1:0] byte_v;
  logic [HalfW-1:0] half_v;

  always_comb begin
    byte_v = old_word[lane * ByteW +: ByteW];
    half_v = old_word[lane[1] * HalfW +: HalfW];
  end

  always_comb begin
    load_data = old_word;
    unique case (size)
      SZ_BYTE: load_data = {{(DATA_W - ByteW){is_signed & byte_v[ByteW-1]}}, byte_v};
      SZ_HALF: load_data = {{(DATA_W - HalfW){is_signed & half_v[HalfW-1]}}, half_v};
      default: load_data = old_word;
    endcase
  end

  // Only the addressed lanes take new data; the rest keep the word read back from memory.
  always_comb begin
    store_word = old_word;
    unique case (size)
      SZ_BYTE: store_word[lane * ByteW +: ByteW]    = new_data[ByteW-1:0];
      SZ_HALF: store_word[lane[1] * HalfW +: HalfW] = new_data[HalfW-1:0];
      default: store_word = new_data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the execute stage and a word-addressed DataMemory.
// Sub-word stores are done as read-modify-write; illegal accesses answer with an error and no strobes.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MEM_WORDS = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic              ReqWrite,
  input  logic [1:0]        ReqSize,
  input  logic              ReqSigned,
  input  logic [ADDR_W-1:0] ReqAddr,
  input  logic [DATA_W-1:0] ReqWData,
  output logic              RspValid,
  output logic [DATA_W-1:0] RspRData,
  output logic              RspError,
  output logic              MemReadSignal,
  output logic              MemWriteSignal,
  output logic [ADDR_W-1:0] MemAddress,
  output logic [DATA_W-1:0] MemWriteData,
  input  logic [DATA_W-1:0] MemReadData
);

  localparam logic [ADDR_W-3:0] MemWordsW = (ADDR_W - 2)'(MEM_WORDS);

  state_e state_q, state_d;

  logic              ready_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              write_q;
  logic [1:0]        size_q;
  logic              signed_q;
  logic              err_q;

  logic              accept;
  logic              req_err;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] store_word;

  assign accept = ReqValid & ReqReady;

  always_comb begin
    req_err = (ReqSize == SZ_ILL)
            | ((ReqSize == SZ_HALF) & ReqAddr[0])
            | ((ReqSize == SZ_WORD) & (|ReqAddr[1:0]))
            | (ReqAddr[ADDR_W-1:2] >= MemWordsW);
  end

  lsu_lane_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .lane       (addr_q[1:0]),
    .size       (size_q),
    .is_signed  (signed_q),
    .old_word   (rdata_q),
    .new_data   (wdata_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (req_err) begin
            state_d = StRsp;
          end else if (ReqWrite && (ReqSize == SZ_WORD)) begin
            state_d = StWr;
          end else begin
            state_d = StRd;
          end
        end
      end
      StRd:    state_d = write_q ? StWr : StRsp;
      StWr:    state_d = StRsp;
      StRsp:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // ready_q holds ReqReady low for the first cycle after reset release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      write_q  <= 1'b0;
      size_q   <= SZ_BYTE;
      signed_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      if ((state_q == StIdle) && accept) begin
        addr_q   <= ReqAddr;
        wdata_q  <= ReqWData;
        write_q  <= ReqWrite;
        size_q   <= ReqSize;
        signed_q <= ReqSigned;
        err_q    <= req_err;
      end
      if (state_q == StRd) begin
        rdata_q <= MemReadData;
      end
    end
  end

  always_comb begin
    ReqReady       = 1'b0;
    RspValid       = 1'b0;
    RspError       = 1'b0;
    RspRData       = '0;
    MemReadSignal  = 1'b0;
    MemWriteSignal = 1'b0;
    MemAddress     = '0;
    MemWriteData   = '0;
    unique case (state_q)
      StIdle: ReqReady = ready_q;
      StRd: begin
        MemReadSignal = 1'b1;
        MemAddress    = {2'b00, addr_q[ADDR_W-1:2]};
      end
      StWr: begin
        MemWriteSignal = 1'b1;
        MemAddress     = {2'b00, addr_q[ADDR_W-1:2]};
        MemWriteData   = store_word;
      end
      StRsp: begin
        RspValid = 1'b1;
        RspError = err_q;
        RspRData = (err_q || write_q) ? '0 : load_data;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural DataMemory and a word-level reference model.
module tb_load_store_unit;

  logic        clk;
  logic        reset;
  logic        ReqValid;
  logic        ReqReady;
  logic        ReqWrite;
  logic [1:0]  ReqSize;
  logic        ReqSigned;
  logic [31:0] ReqAddr;
  logic [31:0] ReqWData;
  logic        RspValid;
  logic [31:0] RspRData;
  logic        RspError;
  logic        MemReadSignal;
  logic        MemWriteSignal;
  logic [31:0] MemAddress;
  logic [31:0] MemWriteData;
  logic [31:0] MemReadData;

  typedef struct {
    logic [31:0] rdata;
    logic [31:0] wword;
    bit          err;
    bit          store;
    int          lat;
    int          rds;
    int          wrs;
    int          word;
    int          acc;
  } exp_t;

  int          checks;
  int          failures;
  int          cyc;
  int          rd_cnt;
  int          wr_cnt;
  exp_t        q[$];
  logic [31:0] dmem[16];
  logic [31:0] mmem[16];

  load_store_unit #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .MEM_WORDS (16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .ReqValid       (ReqValid),
    .ReqReady       (ReqReady),
    .ReqWrite       (ReqWrite),
    .ReqSize        (ReqSize),
    .ReqSigned      (ReqSigned),
    .ReqAddr        (ReqAddr),
    .ReqWData       (ReqWData),
    .RspValid       (RspValid),
    .RspRData       (RspRData),
    .RspError       (RspError),
    .MemReadSignal  (MemReadSignal),
    .MemWriteSignal (MemWriteSignal),
    .MemAddress     (MemAddress),
    .MemWriteData   (MemWriteData),
    .MemReadData    (MemReadData)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural DataMemory seen by the DUT
  assign MemReadData = (MemAddress < 32'd16) ? dmem[MemAddress[3:0]] : 32'h0;
  always @(posedge clk) begin
    if (MemWriteSignal && (MemAddress < 32'd16)) dmem[MemAddress[3:0]] <= MemWriteData;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, req);
    end
  endtask

  // Reference: works on whole words with shifts and masks, independent of the DUT's sequencing.
  function automatic exp_t model(input bit wr, input logic [1:0] sz, input bit sg,
                                 input logic [31:0] a, input logic [31:0] wd);
    exp_t        e;
    logic [31:0] w;
    int          sh;
    e.word  = int'(a >> 2);
    e.err   = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 0)
              || ((a >> 2) >= 32'd16);
    e.store = wr;
    e.rdata = 32'h0;
    e.wword = 32'h0;
    e.acc   = 0;
    w       = e.err ? 32'h0 : mmem[e.word];
    sh      = 8 * int'(a % 4);
    if (e.err) begin
      e.lat = 1; e.rds = 0; e.wrs = 0;
    end else if (!wr) begin
      e.lat = 2; e.rds = 1; e.wrs = 0;
      if (sz == 2'b00) begin
        e.rdata = (w >> sh) & 32'hFF;
        if (sg && e.rdata >= 32'h80) e.rdata = e.rdata + 32'hFFFF_FF00;
      end else if (sz == 2'b01) begin
        e.rdata = (w >> sh) & 32'hFFFF;
        if (sg && e.rdata >= 32'h8000) e.rdata = e.rdata + 32'hFFFF_0000;
      end else begin
        e.rdata = w;
      end
    end else begin
      e.wrs = 1;
      if (sz == 2'b10) begin
        e.lat = 2; e.rds = 0; e.wword = wd;
      end else if (sz == 2'b00) begin
        e.lat = 3; e.rds = 1;
        e.wword = (w & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
      end else begin
        e.lat = 3; e.rds = 1;
        e.wword = (w & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
      end
    end
    return e;
  endfunction

  // Compare process: strobes, addresses, write data and responses against the queued expectation.
  initial begin
    rd_cnt = 0;
    wr_cnt = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        rd_cnt = 0;
        wr_cnt = 0;
        chk("reset_outputs",
            {26'h0, ReqReady, RspValid, RspError, MemReadSignal, MemWriteSignal, 1'b0}, 32'h0);
        chk("reset_rdata", RspRData, 32'h0);
        chk("reset_memaddr", MemAddress, 32'h0);
      end else begin
        if (MemReadSignal) begin
          rd_cnt++;
          if (q.size() == 0) chk("stray_read", 32'h1, 32'h0);
          else chk("rd_addr", MemAddress, q[0].word);
        end
        if (MemWriteSignal) begin
          wr_cnt++;
          if (q.size() == 0) begin
            chk("stray_write", 32'h1, 32'h0);
          end else begin
            chk("wr_addr", MemAddress, q[0].word);
            chk("wr_data", MemWriteData, q[0].wword);
          end
        end
        if (RspValid) begin
          if (q.size() == 0) begin
            chk("unexpected_rsp", 32'h1, 32'h0);
          end else begin
            exp_t e;
            e = q.pop_front();
            chk("rsp_rdata", RspRData, e.rdata);
            chk("rsp_error", {31'h0, RspError}, {31'h0, e.err});
            chk("rsp_latency", cyc - e.acc, e.lat);
            chk("rd_strobes", rd_cnt, e.rds);
            chk("wr_strobes", wr_cnt, e.wrs);
            chk("rsp_memaddr", MemAddress, 32'h0);
            if (e.store && !e.err) mmem[e.word] = e.wword;
          end
          rd_cnt = 0;
          wr_cnt = 0;
        end
      end
    end
  end

  task automatic drive(input bit wr, input logic [1:0] sz, input bit sg,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] lit);
    exp_t e;
    int   t;
    t = 0;
    while (!ReqReady && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!ReqReady) begin
      chk("req_ready_timeout", 32'h0, 32'h1);
      return;
    end
    e = model(wr, sz, sg, a, wd);
    chk("model_pin", wr ? e.wword : e.rdata, lit);
    e.acc = cyc;
    q.push_back(e);
    ReqValid  = 1'b1;
    ReqWrite  = wr;
    ReqSize   = sz;
    ReqSigned = sg;
    ReqAddr   = a;
    ReqWData  = wd;
    @(posedge clk);
    #1 ReqValid = 1'b0;
  endtask

  task automatic do_req(input bit wr, input logic [1:0] sz, input bit sg,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] lit);
    int t;
    drive(wr, sz, sg, a, wd, lit);
    t = 0;
    while (q.size() != 0 && t < 20) begin
      @(negedge clk);
      #1 t++;
    end
    if (q.size() != 0) begin
      chk("rsp_timeout", 32'h0, 32'h1);
      q.delete();
    end else begin
      @(negedge clk);
      chk("ready_after_rsp", {31'h0, ReqReady}, 32'h1);
    end
  endtask

  initial begin
    int t;
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 16; i++) begin
      dmem[i] = i * 32'h0101_0101;
      mmem[i] = i * 32'h0101_0101;
    end
    dmem[2]   = 32'hDEAD_BEEF;
    mmem[2]   = 32'hDEAD_BEEF;
    reset     = 1'b1;
    ReqValid  = 1'b0;
    ReqWrite  = 1'b0;
    ReqSize   = 2'b00;
    ReqSigned = 1'b0;
    ReqAddr   = 32'h0;
    ReqWData  = 32'h0;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", {31'h0, ReqReady}, 32'h1);

    do_req(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 32'hDEAD_BEEF);
    do_req(1'b0, 2'b00, 1'b1, 32'hB, 32'h0, 32'hFFFF_FFDE);
    do_req(1'b0, 2'b00, 1'b0, 32'hB, 32'h0, 32'h0000_00DE);
    do_req(1'b0, 2'b01, 1'b1, 32'hA, 32'h0, 32'hFFFF_DEAD);
    do_req(1'b0, 2'b01, 1'b0, 32'h8, 32'h0, 32'h0000_BEEF);
    do_req(1'b0, 2'b00, 1'b1, 32'h8, 32'h0, 32'hFFFF_FFEF);
    do_req(1'b1, 2'b00, 1'b0, 32'h9, 32'h55, 32'hDEAD_55EF);
    do_req(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 32'hDEAD_55EF);
    do_req(1'b0, 2'b10, 1'b0, 32'h6, 32'h0, 32'h0);
    do_req(1'b0, 2'b01, 1'b0, 32'h3, 32'h0, 32'h0);
    do_req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h0);
    do_req(1'b1, 2'b11, 1'b0, 32'h0, 32'hFFFF_FFFF, 32'h0);
    do_req(1'b1, 2'b10, 1'b0, 32'hC, 32'h1234_5678, 32'h1234_5678);
    do_req(1'b1, 2'b01, 1'b0, 32'hE, 32'hFFFF_A5A5, 32'hA5A5_5678);
    do_req(1'b0, 2'b01, 1'b1, 32'hE, 32'h0, 32'hFFFF_A5A5);
    do_req(1'b0, 2'b10, 1'b0, 32'hC, 32'h0, 32'hA5A5_5678);

    // Abort a read-modify-write in its write cycle: no response and no memory update.
    drive(1'b1, 2'b00, 1'b0, 32'h4, 32'h77, 32'h0101_0177);
    t = 0;
    while (!MemWriteSignal && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("wr_cycle_reached", {31'h0, MemWriteSignal}, 32'h1);
    #2 reset = 1'b1;
    #1 chk("wr_drop_on_reset", {31'h0, MemWriteSignal}, 32'h0);
    q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_abort", {31'h0, ReqReady}, 32'h1);
    do_req(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 32'h0101_0101);
    do_req(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 32'hDEAD_55EF);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
